// File: rtl/riscv_pkg.sv
// Shared types for the EX->MEM boundary: memory/writeback control bits,
// the default-width pipeline entry and the skid buffer state encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int F3_W       = 3;
    localparam int REG_ZERO   = 0;

    // Control bits carried with an instruction into MEM/WB, MSB first.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    // Default-width EX->MEM entry as seen by neighbouring stages.
    typedef struct packed {
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      store_data;
        logic [REG_IDX_W-1:0] rd;
        logic [F3_W-1:0]      funct3;
        ex_mem_ctrl_t         ctrl;
    } ex_mem_entry_t;

    // Occupancy of the 2-entry skid buffer, encoded as {skid_v, head_v}.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_BUSY  = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_t;

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer. in_ready is a flop, so the
// upstream ready never depends combinationally on out_ready; the second
// entry absorbs the one beat that arrives while the stall propagates.
// Handshake: a beat moves on a side exactly when that side's valid and
// ready are both high at a rising clock edge; flush drops everything held.
module skid_buf
    import riscv_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  T           in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output buf_state_t state
);

    T           head_q;
    T           skid_q;
    buf_state_t state_q;
    logic       in_ready_q;
    logic       accept;
    logic       consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = (state_q != BUF_EMPTY) && out_ready;

    // Occupancy FSM with registered in_ready; data moves head<-in, skid<-in, head<-skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Only the valids are killed; stale data is harmless while invalid.
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_q  <= in_data;
                        state_q <= BUF_BUSY;
                    end
                end
                BUF_BUSY: begin
                    if (accept && consume) begin
                        head_q <= in_data;
                    end else if (accept) begin
                        skid_q     <= in_data;
                        state_q    <= BUF_FULL;
                        in_ready_q <= 1'b0;
                    end else if (consume) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (consume) begin
                        head_q     <= skid_q;
                        state_q    <= BUF_BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BUF_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_q;
    assign state     = state_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register built on a 2-entry skid buffer. Masks
// RegWrite for x0 at capture and drives EX forwarding taps from the head.
// Optional EX_MEM_PERF_CNT_EN adds saturating stall and flush counters.
module ex_mem_pipe
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FUNCT3_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [FUNCT3_W-1:0]   funct3_i,
    input  ex_mem_ctrl_t          ctrl_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [FUNCT3_W-1:0]   funct3_o,
    output ex_mem_ctrl_t          ctrl_o,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [FUNCT3_W-1:0]   funct3;
        ex_mem_ctrl_t          ctrl;
    } entry_t;

    entry_t     cap_entry;
    entry_t     head_entry;
    buf_state_t buf_state;
    logic       rd_is_zero;

    assign rd_is_zero = (rd_i == REG_ADDR_W'(REG_ZERO));

    // Capture path: x0 never carries a write, so it can never be forwarded.
    always_comb begin
        cap_entry                = '0;
        cap_entry.alu_result     = alu_result_i;
        cap_entry.store_data     = store_data_i;
        cap_entry.rd             = rd_i;
        cap_entry.funct3         = funct3_i;
        cap_entry.ctrl           = ctrl_i;
        cap_entry.ctrl.reg_write = ctrl_i.reg_write && !rd_is_zero;
    end

    skid_buf #(
        .T (entry_t)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cap_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry),
        .state     (buf_state)
    );

    assign alu_result_o = head_entry.alu_result;
    assign store_data_o = head_entry.store_data;
    assign rd_o         = head_entry.rd;
    assign funct3_o     = head_entry.funct3;
    assign ctrl_o       = head_entry.ctrl;

    assign fwd_valid = out_valid && head_entry.ctrl.reg_write &&
                       (head_entry.rd != REG_ADDR_W'(REG_ZERO));
    assign fwd_rd    = head_entry.rd;
    assign fwd_data  = head_entry.alu_result;

`ifdef EX_MEM_PERF_CNT_EN
    // Saturating counters of MEM stall cycles and flushes that killed work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && out_valid && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A load and a store in one instruction is malformed decode; flag it at capture.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            assert (!(ctrl_i.mem_read && ctrl_i.mem_write));
        end
        if (rst_n) begin
            assert (in_ready == (buf_state != BUF_FULL));
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios plus a randomized
// run compared against a queue-based FIFO model of the stage.
module tb_ex_mem_pipe;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] alu_result_i = '0;
    logic [DW-1:0] store_data_i = '0;
    logic [RW-1:0] rd_i = '0;
    logic [FW-1:0] funct3_i = '0;
    ex_mem_ctrl_t  ctrl_i = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] alu_result_o;
    logic [DW-1:0] store_data_o;
    logic [RW-1:0] rd_o;
    logic [FW-1:0] funct3_o;
    ex_mem_ctrl_t  ctrl_o;
    logic          fwd_valid;
    logic [RW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
        logic [RW-1:0] rd;
        logic [FW-1:0] f3;
        ex_mem_ctrl_t  ctrl;
    } exp_t;

    exp_t exp_q[$];

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    ex_mem_pipe #(
        .DATA_WIDTH (DW),
        .REG_ADDR_W (RW),
        .FUNCT3_W   (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .rd_i         (rd_i),
        .funct3_i     (funct3_i),
        .ctrl_i       (ctrl_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result_o (alu_result_o),
        .store_data_o (store_data_o),
        .rd_o         (rd_o),
        .funct3_o     (funct3_o),
        .ctrl_o       (ctrl_o),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // Driver: advance one clock edge, updating the FIFO model from the
    // inputs that were presented at that edge; returns 1 time unit after it.
    task automatic tick();
        exp_t e;
        bit   acc;
        bit   con;
        acc = in_valid && (exp_q.size() < 2);
        con = out_ready && (exp_q.size() > 0);
        e.alu  = alu_result_i;
        e.sd   = store_data_i;
        e.rd   = rd_i;
        e.f3   = funct3_i;
        e.ctrl = ctrl_i;
        e.ctrl.reg_write = ctrl_i.reg_write && (rd_i != '0);
        @(posedge clk);
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (con) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a,
                         input logic [RW-1:0] r, input ex_mem_ctrl_t c);
        in_valid     = v;
        alu_result_i = a;
        store_data_i = DW'($urandom);
        rd_i         = r;
        funct3_i     = FW'($urandom_range(0, 7));
        ctrl_i       = c;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b required 0", fwd_valid); end
        checks++; if (alu_result_o !== '0 || store_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h/%h required 0", alu_result_o, store_data_o); end
        checks++; if (rd_o !== '0 || funct3_o !== '0 || ctrl_o !== '0) begin errors++; $display("FAIL reset_ctrl: got rd=%h f3=%h ctrl=%h required 0", rd_o, funct3_o, ctrl_o); end
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_single_op();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0007, 5'd5, '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0});
        tick();
        drive(1'b0, '0, '0, '0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", out_valid); end
        checks++; if (alu_result_o !== 32'h7) begin errors++; $display("FAIL single_alu: got %h required 7", alu_result_o); end
        checks++; if (fwd_valid !== 1'b1) begin errors++; $display("FAIL single_fwd_valid: got %b required 1", fwd_valid); end
        checks++; if (fwd_rd !== 5'd5) begin errors++; $display("FAIL single_fwd_rd: got %0d required 5", fwd_rd); end
        checks++; if (fwd_data !== 32'h7) begin errors++; $display("FAIL single_fwd_data: got %h required 7", fwd_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        ex_mem_ctrl_t c;
        c = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0};
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, c);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a: got %b required 1", in_ready); end
        drive(1'b1, 32'h22, 5'd2, c);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b: got %b required 0", in_ready); end
        drive(1'b1, 32'h33, 5'd3, c);
        tick();
        checks++; if (out_valid !== 1'b1 || alu_result_o !== 32'h11) begin errors++; $display("FAIL bp_hold: got v=%b %h required v=1 11", out_valid, alu_result_o); end
        checks++; if (rd_o !== 5'd1) begin errors++; $display("FAIL bp_hold_rd: got %0d required 1", rd_o); end
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || alu_result_o !== 32'h22) begin errors++; $display("FAIL bp_second: got v=%b %h required v=1 22", out_valid, alu_result_o); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b required 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c_dropped: got v=%b %h required v=0", out_valid, alu_result_o); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 5'd7, '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b1});
            tick();
            checks++; if (out_valid !== 1'b1 || alu_result_o !== DW'(i)) begin errors++; $display("FAIL stream_%0d: got v=%b %h required v=1 %h", i, out_valid, alu_result_o, DW'(i)); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b required 1", i, in_ready); end
        end
        drive(1'b0, '0, '0, '0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_x0_write();
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 5'd0, '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0});
        tick();
        drive(1'b0, '0, '0, '0);
        checks++; if (out_valid !== 1'b1 || alu_result_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_entry: got v=%b %h required v=1 deadbeef", out_valid, alu_result_o); end
        checks++; if (ctrl_o.reg_write !== 1'b0) begin errors++; $display("FAIL x0_regwrite: got %b required 0", ctrl_o.reg_write); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL x0_fwd_valid: got %b required 0", fwd_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        ex_mem_ctrl_t c;
        c = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1};
        out_ready = 1'b0;
        drive(1'b1, 32'h41, 5'd4, c);
        tick();
        drive(1'b1, 32'h42, 5'd4, c);
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: got in_ready=%b required 0", in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h99, 5'd9, c);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_99_%0d: got v=%b %h required v=0", i, out_valid, alu_result_o); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 5'd6, '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0});
        tick();
        drive(1'b1, 32'h66, 5'd6, '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0});
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b required 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b required 1", in_ready); end
        checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL arst_fwd: got %b required 0", fwd_valid); end
        drive(1'b0, '0, '0, '0);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_release: got %b required 0", out_valid); end
    endtask

    task automatic test_random();
        ex_mem_ctrl_t c;
        int           mem_op;
        for (int cyc = 0; cyc < 600; cyc++) begin
            mem_op = $urandom_range(0, 2);
            c.reg_write  = 1'($urandom_range(0, 1));
            c.mem_read   = (mem_op == 1);
            c.mem_write  = (mem_op == 2);
            c.mem_to_reg = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom), RW'($urandom_range(0, 31)), c);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            tick();
            checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d: got %b required %b", cyc, out_valid, exp_q.size() > 0); end
            checks++; if (in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d: got %b required %b", cyc, in_ready, exp_q.size() < 2); end
            if (exp_q.size() > 0) begin
                checks++; if (alu_result_o !== exp_q[0].alu || fwd_data !== exp_q[0].alu) begin errors++; $display("FAIL rnd_alu cyc %0d: got %h/%h required %h", cyc, alu_result_o, fwd_data, exp_q[0].alu); end
                checks++; if (store_data_o !== exp_q[0].sd) begin errors++; $display("FAIL rnd_sd cyc %0d: got %h required %h", cyc, store_data_o, exp_q[0].sd); end
                checks++; if (rd_o !== exp_q[0].rd || fwd_rd !== exp_q[0].rd) begin errors++; $display("FAIL rnd_rd cyc %0d: got %0d/%0d required %0d", cyc, rd_o, fwd_rd, exp_q[0].rd); end
                checks++; if (funct3_o !== exp_q[0].f3) begin errors++; $display("FAIL rnd_f3 cyc %0d: got %h required %h", cyc, funct3_o, exp_q[0].f3); end
                checks++; if (ctrl_o !== exp_q[0].ctrl) begin errors++; $display("FAIL rnd_ctrl cyc %0d: got %b required %b", cyc, ctrl_o, exp_q[0].ctrl); end
                checks++; if (fwd_valid !== (exp_q[0].ctrl.reg_write && exp_q[0].rd != '0)) begin errors++; $display("FAIL rnd_fwd cyc %0d: got %b required %b", cyc, fwd_valid, exp_q[0].ctrl.reg_write && exp_q[0].rd != '0); end
            end else begin
                checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rnd_fwd_idle cyc %0d: got %b required 0", cyc, fwd_valid); end
            end
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

`ifdef EX_MEM_PERF_CNT_EN
    task automatic test_perf_counters();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d required 0/0", stall_cnt, flush_cnt); end
        out_ready = 1'b0;
        drive(1'b1, 32'hAB, 5'd3, '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0});
        tick();
        drive(1'b0, '0, '0, '0);
        repeat (5) tick();
        checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d required 5", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL perf_flush: got %0d required 1", flush_cnt); end
        tick();
        checks++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd6) begin errors++; $display("FAIL perf_idle: got %0d/%0d required 1/6", flush_cnt, stall_cnt); end
        out_ready = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_back_pressure();
        test_streaming();
        test_x0_write();
        test_flush();
        test_async_reset();
        test_random();
`ifdef EX_MEM_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
